// File: rtl/indice_buffer_loader_pkg.sv
// Shared types and width derivations for the column-index double-buffer loader.
package indice_buffer_loader_pkg;

    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_sel_t;

    typedef enum logic {
        FILL      = 1'b0,
        WAIT_FREE = 1'b1
    } state_t;

    localparam int DEFAULT_K = 1024;

    function automatic int addrWidth(input int k);
        return $clog2(k * k / 32);
    endfunction

    function automatic int idxWidth(input int k);
        return $clog2(k);
    endfunction

    function automatic int cntWidth(input int addrW);
        return addrW + 1;
    endfunction

endpackage

// File: rtl/indice_buffer_loader_if.sv
// Valid/ready index stream feeding the loader: up to two indices per beat.
interface indice_buffer_loader_if
    import indice_buffer_loader_pkg::*;
#(
    parameter int IDX_W = idxWidth(DEFAULT_K)
);

    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx0;
    logic [IDX_W-1:0] in_idx1;
    logic [1:0]       in_cnt;
    logic             in_last;

    modport master (
        output in_valid,
        output in_idx0,
        output in_idx1,
        output in_cnt,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_idx0,
        input  in_idx1,
        input  in_cnt,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/indice_buffer_loader_bank_port_mux.sv
// Per-bank port selection: the write stage owns the bank when it targets it,
// otherwise the consumer's read request drives the ports.
module bank_port_mux
    import indice_buffer_loader_pkg::*;
#(
    parameter int ADDR_W = addrWidth(DEFAULT_K),
    parameter int IDX_W  = idxWidth(DEFAULT_K)
) (
    input  logic              wrSel,
    input  logic              wrEn1,
    input  logic              wrEn2,
    input  logic [ADDR_W-1:0] wrAddr1,
    input  logic [ADDR_W-1:0] wrAddr2,
    input  logic [IDX_W-1:0]  wrData1,
    input  logic [IDX_W-1:0]  wrData2,
    input  logic              consRdEn,
    input  logic [ADDR_W-1:0] consAddr1,
    input  logic [ADDR_W-1:0] consAddr2,
    output logic              enable,
    output logic              writeEnable1,
    output logic              writeEnable2,
    output logic [ADDR_W-1:0] address1,
    output logic [ADDR_W-1:0] address2,
    output logic [IDX_W-1:0]  writeData1,
    output logic [IDX_W-1:0]  writeData2
);

    always_comb begin
        enable       = consRdEn;
        writeEnable1 = 1'b0;
        writeEnable2 = 1'b0;
        address1     = consAddr1;
        address2     = consAddr2;
        writeData1   = wrData1;
        writeData2   = wrData2;
        if (wrSel) begin
            enable       = 1'b1;
            writeEnable1 = wrEn1;
            writeEnable2 = wrEn2;
            address1     = wrAddr1;
            address2     = wrAddr2;
        end
    end

endmodule

// File: rtl/indice_buffer_loader.sv
// Fill stage for the ping-pong column-index buffer: writes the input stream into
// the current fill bank and hands completed banks to the consumer.
module indice_buffer_loader
    import indice_buffer_loader_pkg::*;
#(
    parameter int K      = DEFAULT_K,
    parameter int ADDR_W = addrWidth(K),
    parameter int IDX_W  = idxWidth(K),
    parameter int DEPTH  = 2 ** ADDR_W,
    parameter int CNT_W  = cntWidth(ADDR_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    indice_buffer_loader_if.slave inStream,
    output logic [1:0]           bank_valid,
    output logic [CNT_W-1:0]     bank_count_a,
    output logic [CNT_W-1:0]     bank_count_b,
    input  logic [1:0]           cons_release,
    input  logic [1:0]           cons_rd_en,
    input  logic [ADDR_W-1:0]    cons_addr1,
    input  logic [ADDR_W-1:0]    cons_addr2,
    output logic                 err_overflow,
    output logic                 enableA,
    output logic                 enableB,
    output logic                 writeEnableA1,
    output logic                 writeEnableA2,
    output logic                 writeEnableB1,
    output logic                 writeEnableB2,
    output logic [ADDR_W-1:0]    addressportA1,
    output logic [ADDR_W-1:0]    addressportA2,
    output logic [ADDR_W-1:0]    addressportB1,
    output logic [ADDR_W-1:0]    addressportB2,
    output logic [IDX_W-1:0]     writeportA1,
    output logic [IDX_W-1:0]     writeportA2,
    output logic [IDX_W-1:0]     writeportB1,
    output logic [IDX_W-1:0]     writeportB2
);

    localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(DEPTH);

    state_t           state;
    bank_sel_t        fillSel;
    logic [CNT_W-1:0] wrPtr;
    logic [1:0]       bankValid;
    logic [CNT_W-1:0] countA;
    logic [CNT_W-1:0] countB;
    logic             errOverflow;

    logic              pipeWe1;
    logic              pipeWe2;
    logic              pipeLast;
    bank_sel_t         pipeBank;
    logic [ADDR_W-1:0] pipeAddr1;
    logic [ADDR_W-1:0] pipeAddr2;
    logic [IDX_W-1:0]  pipeData1;
    logic [IDX_W-1:0]  pipeData2;
    logic [CNT_W-1:0]  pipeCount;

    logic             accept;
    logic             want0;
    logic             want1;
    logic             fit0;
    logic             fit1;
    logic [CNT_W:0]   ptrExt;
    logic [CNT_W:0]   ptrSum;
    logic [CNT_W-1:0] nextPtr;
    logic [1:0]       setVec;
    logic [1:0]       nextValid;
    bank_sel_t        otherBank;

    assign inStream.in_ready = (state == FILL);
    assign accept            = inStream.in_valid && inStream.in_ready;

    always_comb begin
        want0   = (inStream.in_cnt != 2'd0);
        want1   = (inStream.in_cnt == 2'd2);
        ptrExt  = {1'b0, wrPtr};
        fit0    = (ptrExt < DEPTH_EXT);
        fit1    = ((ptrExt + 1'b1) < DEPTH_EXT);
        ptrSum  = ptrExt + (CNT_W + 1)'(inStream.in_cnt);
        nextPtr = (ptrSum > DEPTH_EXT) ? CNT_W'(DEPTH_EXT) : CNT_W'(ptrSum);
        otherBank = (fillSel == BANK_A) ? BANK_B : BANK_A;
        setVec  = 2'b00;
        if (pipeLast) begin
            setVec = (pipeBank == BANK_A) ? 2'b01 : 2'b10;
        end
        // A set landing in the same cycle as a release of that bank wins.
        nextValid = setVec | (bankValid & ~cons_release);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            fillSel     <= BANK_A;
            wrPtr       <= '0;
            bankValid   <= '0;
            countA      <= '0;
            countB      <= '0;
            errOverflow <= 1'b0;
            pipeWe1     <= 1'b0;
            pipeWe2     <= 1'b0;
            pipeLast    <= 1'b0;
            pipeBank    <= BANK_A;
            pipeAddr1   <= '0;
            pipeAddr2   <= '0;
            pipeData1   <= '0;
            pipeData2   <= '0;
            pipeCount   <= '0;
        end else begin
            bankValid <= nextValid;
            if (pipeLast) begin
                if (pipeBank == BANK_A) countA <= pipeCount;
                else                    countB <= pipeCount;
            end

            pipeWe1  <= 1'b0;
            pipeWe2  <= 1'b0;
            pipeLast <= 1'b0;

            case (state)
                FILL: begin
                    if (accept) begin
                        pipeWe1   <= want0 && fit0;
                        pipeWe2   <= want1 && fit1;
                        pipeLast  <= inStream.in_last;
                        pipeBank  <= fillSel;
                        pipeAddr1 <= ADDR_W'(wrPtr);
                        pipeAddr2 <= ADDR_W'(wrPtr + 1'b1);
                        pipeData1 <= inStream.in_idx0;
                        pipeData2 <= inStream.in_idx1;
                        pipeCount <= nextPtr;
                        if ((want0 && !fit0) || (want1 && !fit1)) begin
                            errOverflow <= 1'b1;
                        end
                        // Switching banks here lets the very next beat target the
                        // new bank while the last write of the old one commits.
                        if (inStream.in_last) begin
                            fillSel <= otherBank;
                            wrPtr   <= '0;
                            state   <= nextValid[otherBank] ? WAIT_FREE : FILL;
                        end else begin
                            wrPtr <= nextPtr;
                        end
                    end
                end
                WAIT_FREE: begin
                    if (!nextValid[fillSel]) begin
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bank_valid   = bankValid;
    assign bank_count_a = countA;
    assign bank_count_b = countB;
    assign err_overflow = errOverflow;

    logic wrSelA;
    logic wrSelB;
    assign wrSelA = (pipeWe1 || pipeWe2) && (pipeBank == BANK_A);
    assign wrSelB = (pipeWe1 || pipeWe2) && (pipeBank == BANK_B);

    bank_port_mux #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) muxA (
        .wrSel        (wrSelA),
        .wrEn1        (pipeWe1),
        .wrEn2        (pipeWe2),
        .wrAddr1      (pipeAddr1),
        .wrAddr2      (pipeAddr2),
        .wrData1      (pipeData1),
        .wrData2      (pipeData2),
        .consRdEn     (cons_rd_en[0]),
        .consAddr1    (cons_addr1),
        .consAddr2    (cons_addr2),
        .enable       (enableA),
        .writeEnable1 (writeEnableA1),
        .writeEnable2 (writeEnableA2),
        .address1     (addressportA1),
        .address2     (addressportA2),
        .writeData1   (writeportA1),
        .writeData2   (writeportA2)
    );

    bank_port_mux #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) muxB (
        .wrSel        (wrSelB),
        .wrEn1        (pipeWe1),
        .wrEn2        (pipeWe2),
        .wrAddr1      (pipeAddr1),
        .wrAddr2      (pipeAddr2),
        .wrData1      (pipeData1),
        .wrData2      (pipeData2),
        .consRdEn     (cons_rd_en[1]),
        .consAddr1    (cons_addr1),
        .consAddr2    (cons_addr2),
        .enable       (enableB),
        .writeEnable1 (writeEnableB1),
        .writeEnable2 (writeEnableB2),
        .address1     (addressportB1),
        .address2     (addressportB2),
        .writeData1   (writeportB1),
        .writeData2   (writeportB2)
    );

endmodule

// File: tb/tb_indice_buffer_loader.sv
// Directed bench for indice_buffer_loader: K=64 main instance plus a DEPTH=4 instance.
module tb_indice_buffer_loader;

    localparam int AW = 7;
    localparam int IW = 6;
    localparam int CW = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    indice_buffer_loader_if #(.IDX_W(IW)) ib0 ();
    indice_buffer_loader_if #(.IDX_W(IW)) ib1 ();

    logic [1:0]    bv0, bv1, rel0, rel1, rd0;
    logic [CW-1:0] cA0, cB0, cA1, cB1;
    logic [AW-1:0] ca1, ca2;
    logic          err0, err1;
    logic          enA0, enB0, weA10, weA20, weB10, weB20;
    logic [AW-1:0] adA10, adA20, adB10, adB20;
    logic [IW-1:0] dA10, dA20, dB10, dB20;
    logic          enA1, enB1, weA11, weA21, weB11, weB21;
    logic [AW-1:0] adA11, adA21, adB11, adB21;
    logic [IW-1:0] dA11, dA21, dB11, dB21;

    indice_buffer_loader #(.K(64)) u0 (
        .clk(clk), .rst(rst), .inStream(ib0),
        .bank_valid(bv0), .bank_count_a(cA0), .bank_count_b(cB0),
        .cons_release(rel0), .cons_rd_en(rd0), .cons_addr1(ca1), .cons_addr2(ca2),
        .err_overflow(err0), .enableA(enA0), .enableB(enB0),
        .writeEnableA1(weA10), .writeEnableA2(weA20), .writeEnableB1(weB10), .writeEnableB2(weB20),
        .addressportA1(adA10), .addressportA2(adA20), .addressportB1(adB10), .addressportB2(adB20),
        .writeportA1(dA10), .writeportA2(dA20), .writeportB1(dB10), .writeportB2(dB20)
    );

    indice_buffer_loader #(.K(64), .DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .inStream(ib1),
        .bank_valid(bv1), .bank_count_a(cA1), .bank_count_b(cB1),
        .cons_release(rel1), .cons_rd_en(2'b00), .cons_addr1('0), .cons_addr2('0),
        .err_overflow(err1), .enableA(enA1), .enableB(enB1),
        .writeEnableA1(weA11), .writeEnableA2(weA21), .writeEnableB1(weB11), .writeEnableB2(weB21),
        .addressportA1(adA11), .addressportA2(adA21), .addressportB1(adB11), .addressportB2(adB21),
        .writeportA1(dA11), .writeportA2(dA21), .writeportB1(dB11), .writeportB2(dB21)
    );

    // Bank A RAM of u0: read latency 2
    logic [IW-1:0] memA [0:127];
    logic [IW-1:0] rq1, rq2, rdA1, rdA2;
    always @(posedge clk) begin
        if (enA0) begin
            if (weA10) memA[adA10] <= dA10;
            if (weA20) memA[adA20] <= dA20;
            rq1 <= memA[adA10];
            rq2 <= memA[adA20];
        end
        rdA1 <= rq1;
        rdA2 <= rq2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic beat0(input logic v, input int i0, input int i1, input int cnt, input logic last);
        ib0.in_valid = v;
        ib0.in_idx0  = IW'(i0);
        ib0.in_idx1  = IW'(i1);
        ib0.in_cnt   = 2'(cnt);
        ib0.in_last  = last;
    endtask

    task automatic beat1(input logic v, input int i0, input int i1, input int cnt, input logic last);
        ib1.in_valid = v;
        ib1.in_idx0  = IW'(i0);
        ib1.in_idx1  = IW'(i1);
        ib1.in_cnt   = 2'(cnt);
        ib1.in_last  = last;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        rel0  = 2'b00;
        rel1  = 2'b00;
        rd0   = 2'b00;
        ca1   = '0;
        ca2   = '0;
        beat0(1'b0, 0, 0, 0, 1'b0);
        beat1(1'b0, 0, 0, 0, 1'b0);

        // Reset
        step;
        step;
        chk("rst_ready", 32'(ib0.in_ready), 1);
        chk("rst_bv", 32'(bv0), 0);
        chk("rst_we", 32'({weA10, weA20, weB10, weB20}), 0);
        chk("rst_err", 32'(err0), 0);
        rst = 1'b0;

        // Fill A: 5,9 / 3,7 / 1 (last)
        beat0(1'b1, 5, 9, 2, 1'b0);
        step;
        chk("a0_we", 32'({weA10, weA20, weB10, weB20}), 4'b1100);
        chk("a0_addr", 32'({adA10, adA20}), {7'd0, 7'd1});
        chk("a0_data", 32'({dA10, dA20}), {6'd5, 6'd9});
        beat0(1'b1, 3, 7, 2, 1'b0);
        step;
        chk("a1_addr", 32'({adA10, adA20}), {7'd2, 7'd3});
        chk("a1_data", 32'({dA10, dA20}), {6'd3, 6'd7});
        beat0(1'b1, 1, 0, 1, 1'b1);
        step;
        chk("a2_we", 32'({weA10, weA20}), 2'b10);
        chk("a2_addr_data", 32'({adA10, dA10}), {7'd4, 6'd1});
        chk("a2_bv_not_yet", 32'(bv0), 0);
        chk("a2_ready", 32'(ib0.in_ready), 1);
        beat0(1'b0, 0, 0, 0, 1'b0);
        step;
        chk("a_bv", 32'(bv0), 2'b01);
        chk("a_count", 32'(cA0), 5);
        chk("a_ready", 32'(ib0.in_ready), 1);
        chk("a_idle_we", 32'({weA10, weA20, enA0}), 0);

        // Fill B (single last beat) while consumer reads A addr 2/3
        beat0(1'b1, 11, 12, 2, 1'b1);
        rd0 = 2'b01;
        ca1 = 7'd2;
        ca2 = 7'd3;
        step;
        chk("rdA_ports", 32'({enA0, weA10, weA20, adA10, adA20}), {1'b1, 1'b0, 1'b0, 7'd2, 7'd3});
        chk("b_we", 32'({weB10, weB20, enB0}), 3'b111);
        chk("b_addr_data", 32'({adB10, adB20, dB10, dB20}), {7'd0, 7'd1, 6'd11, 6'd12});
        chk("b_waitfree", 32'(ib0.in_ready), 0);
        beat0(1'b0, 0, 0, 0, 1'b0);
        rd0 = 2'b00;
        step;
        chk("rdA_data", 32'({rdA1, rdA2}), {6'd3, 6'd7});
        chk("b_bv", 32'(bv0), 2'b11);
        chk("b_count", 32'(cB0), 2);
        chk("b_still_wait", 32'(ib0.in_ready), 0);

        // Release A -> FILL next cycle
        rel0 = 2'b01;
        step;
        rel0 = 2'b00;
        chk("rel_ready", 32'(ib0.in_ready), 1);
        chk("rel_bv", 32'(bv0), 2'b10);
        beat0(1'b1, 21, 22, 2, 1'b0);
        step;
        chk("a2nd_we", 32'({weA10, weA20, weB10, weB20}), 4'b1100);
        chk("a2nd_addr", 32'({adA10, adA20, dA10}), {7'd0, 7'd1, 6'd21});

        // Last on A together with release of B: no WAIT_FREE
        beat0(1'b1, 23, 0, 1, 1'b1);
        rel0 = 2'b10;
        step;
        rel0 = 2'b00;
        chk("ab_ready", 32'(ib0.in_ready), 1);
        chk("ab_write", 32'({weA10, weA20, adA10, dA10}), {1'b1, 1'b0, 7'd2, 6'd23});
        chk("ab_bv", 32'(bv0), 0);
        beat0(1'b0, 0, 0, 0, 1'b0);
        step;
        chk("ab_bv2", 32'(bv0), 2'b01);
        chk("ab_count", 32'(cA0), 3);

        // Last on B together with release of A
        beat0(1'b1, 31, 32, 2, 1'b1);
        rel0 = 2'b01;
        step;
        rel0 = 2'b00;
        chk("ba_ready", 32'(ib0.in_ready), 1);
        chk("ba_write", 32'({weB10, weB20, adB10, dB10}), {1'b1, 1'b1, 7'd0, 6'd31});
        chk("ba_bv", 32'(bv0), 0);
        beat0(1'b0, 0, 0, 0, 1'b0);
        step;
        chk("ba_bv2", 32'(bv0), 2'b10);
        chk("ba_count", 32'(cB0), 2);
        chk("ba_ready2", 32'(ib0.in_ready), 1);

        // Reset mid-fill
        beat0(1'b1, 41, 42, 2, 1'b0);
        step;
        chk("mf_we", 32'({weA10, weA20}), 2'b11);
        beat0(1'b1, 43, 44, 2, 1'b0);
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("mf_rst_we", 32'({weA10, weA20, weB10, weB20}), 0);
        chk("mf_rst_bv", 32'(bv0), 0);
        chk("mf_rst_cnt", 32'({cA0, cB0}), 0);
        beat0(1'b1, 50, 51, 2, 1'b1);
        step;
        chk("mf_restart", 32'({weA10, weA20, adA10, adA20, dA10}), {1'b1, 1'b1, 7'd0, 7'd1, 6'd50});
        beat0(1'b0, 0, 0, 0, 1'b0);
        step;
        chk("mf_bv", 32'(bv0), 2'b01);
        chk("mf_count", 32'(cA0), 2);

        // Release of a non-valid bank is ignored
        rel0 = 2'b10;
        step;
        rel0 = 2'b00;
        chk("rel_ignored", 32'(bv0), 2'b01);

        // DEPTH=4 overflow
        beat1(1'b1, 1, 2, 2, 1'b0);
        step;
        chk("ov0", 32'({weA11, weA21, adA11, adA21}), {1'b1, 1'b1, 7'd0, 7'd1});
        beat1(1'b1, 3, 4, 2, 1'b0);
        step;
        chk("ov1", 32'({weA11, weA21, adA11, adA21}), {1'b1, 1'b1, 7'd2, 7'd3});
        chk("ov1_err", 32'(err1), 0);
        beat1(1'b1, 5, 6, 2, 1'b1);
        step;
        chk("ov2_drop", 32'({weA11, weA21, weB11, weB21}), 0);
        chk("ov2_err", 32'(err1), 1);
        beat1(1'b0, 0, 0, 0, 1'b0);
        step;
        chk("ov_bv", 32'(bv1), 2'b01);
        chk("ov_count", 32'(cA1), 4);
        step;
        chk("ov_err_sticky", 32'(err1), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
